reorder_buffer: RTL and testbench

In-order retirement buffer downstream of the reservation station and SLBuffer result buses; it also allocates the ROB tags that issue hands to the Rs.
- Holds up to 15 in-flight instructions and records ex/slb results by tag.
- Commits one instruction per cycle from the head, in program order.
- Detects next-PC mispredicts at commit and raises control_hazard to flush the Rs, SLBuffer, issue and fetch.

---
 rtl/rob_pkg.sv | 26 ++
 rtl/reorder_buffer.sv | 232 +++++++++++++++++++++++
 tb/tb_reorder_buffer.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Shared definitions for the reorder buffer. These cover the entry type
// encodings, the reserved tag and the tag-pointer wrap helper.
package rob_pkg;

    // Default tag width; entries are 1..2**ROB_Q_WIDTH-1
    localparam int ROB_Q_WIDTH = 4;
    localparam int ROB_DEPTH   = 2**ROB_Q_WIDTH - 1;

    // Tag 0 means "no dependency" and is never allocated
    localparam int TAG_NONE = 0;

    // What an entry does when it retires
    typedef enum logic [1:0] {
        ROB_REG    = 2'd0,   // register write
        ROB_BRANCH = 2'd1,   // conditional branch, may redirect
        ROB_STORE  = 2'd2,   // store, released to the SLBuffer at commit
        ROB_JUMP   = 2'd3    // jump-and-link: writes rd and may redirect
    } rob_type_e;

    // Tag pointers step 1..depth and wrap back to 1, skipping TAG_NONE
    function automatic int unsigned next_tag(input int unsigned tag,
                                             input int unsigned depth);
        return (tag >= depth) ? 32'd1 : tag + 32'd1;
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer. It allocates tags at issue and records
// results from the ex and SLBuffer buses. It retires one entry per cycle
// from the head and flushes everything when a branch or jump at the head
// turns out to have been mispredicted.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int Q_WIDTH        = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    // issue side
    input  logic                      issue_valid,
    input  logic [1:0]                issue_type,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
    input  logic [31:0]               issue_pred_npc,
    output logic [Q_WIDTH-1:0]        alloc_tag,
    output logic                      rob_full,
    // ex result bus
    input  logic                      update_control,
    input  logic [Q_WIDTH-1:0]        target_ROB_pos,
    input  logic [31:0]               V_ex,
    input  logic [31:0]               ex_npc,
    // SLBuffer result bus
    input  logic                      has_slb_result,
    input  logic [Q_WIDTH-1:0]        slb_target_ROB_pos,
    input  logic [31:0]               V_slb,
    // operand lookups for issue
    input  logic [Q_WIDTH-1:0]        query_tag1,
    input  logic [Q_WIDTH-1:0]        query_tag2,
    output logic                      query_ready1,
    output logic                      query_ready2,
    output logic [31:0]               query_value1,
    output logic [31:0]               query_value2,
    // commit side
    output logic                      commit_reg_valid,
    output logic [REG_ADDR_WIDTH-1:0] commit_rd,
    output logic [31:0]               commit_value,
    output logic [Q_WIDTH-1:0]        commit_tag,
    output logic                      commit_store_valid,
    output logic                      control_hazard,
    output logic [31:0]               redirect_pc
);

    localparam int NUM_SLOTS = 2**Q_WIDTH;
    localparam int DEPTH     = NUM_SLOTS - 1;

    localparam logic [Q_WIDTH-1:0] NO_TAG    = Q_WIDTH'(TAG_NONE);
    localparam logic [Q_WIDTH-1:0] FIRST_TAG = Q_WIDTH'(1);
    localparam logic [Q_WIDTH-1:0] FULL_CNT  = Q_WIDTH'(DEPTH);
    localparam logic [Q_WIDTH-1:0] ONE       = Q_WIDTH'(1);

    function automatic logic [Q_WIDTH-1:0] step_tag(input logic [Q_WIDTH-1:0] t);
        return Q_WIDTH'(next_tag(32'(t), DEPTH));
    endfunction

    // Pointers and occupancy
    logic [Q_WIDTH-1:0] head_q, head_d;
    logic [Q_WIDTH-1:0] tail_q, tail_d;
    logic [Q_WIDTH-1:0] count_q, count_d;

    // Per-entry control bits (slot 0 is never used)
    logic [NUM_SLOTS-1:0] busy_q;
    logic [NUM_SLOTS-1:0] ready_q;

    // Per-entry payload
    rob_type_e                 type_q     [NUM_SLOTS];
    logic [REG_ADDR_WIDTH-1:0] rd_q       [NUM_SLOTS];
    logic [31:0]               pred_npc_q [NUM_SLOTS];
    logic [31:0]               act_npc_q  [NUM_SLOTS];
    logic [31:0]               value_q    [NUM_SLOTS];

    // Registered commit outputs
    logic                      commit_reg_valid_q;
    logic [REG_ADDR_WIDTH-1:0] commit_rd_q;
    logic [31:0]               commit_value_q;
    logic [Q_WIDTH-1:0]        commit_tag_q;
    logic                      commit_store_valid_q;
    logic                      control_hazard_q;
    logic [31:0]               redirect_pc_q;

    // Per-cycle decisions
    logic      accept;
    logic      alloc_fire;
    logic      ex_wb;
    logic      slb_wb;
    logic      commit_fire;
    logic      mispredict;
    rob_type_e head_type;

    assign rob_full  = (count_q == FULL_CNT);
    assign alloc_tag = tail_q;
    assign head_type = type_q[head_q];

    // While the flush pulse is out, issue and writebacks belong to the wrong path
    assign accept = rdy_in && !control_hazard_q;

    assign alloc_fire = accept && issue_valid && !rob_full;

    assign ex_wb  = accept && update_control && (target_ROB_pos != NO_TAG)
                    && busy_q[target_ROB_pos];
    assign slb_wb = accept && has_slb_result && (slb_target_ROB_pos != NO_TAG)
                    && busy_q[slb_target_ROB_pos];

    assign commit_fire = rdy_in && busy_q[head_q] && ready_q[head_q];

    assign mispredict = commit_fire
                        && ((head_type == ROB_BRANCH) || (head_type == ROB_JUMP))
                        && (act_npc_q[head_q] != pred_npc_q[head_q]);

    // Next pointers and count; a mispredict empties the buffer outright
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (mispredict) begin
            head_d  = FIRST_TAG;
            tail_d  = FIRST_TAG;
            count_d = '0;
        end else begin
            if (alloc_fire)  tail_d = step_tag(tail_q);
            if (commit_fire) head_d = step_tag(head_q);
            case ({alloc_fire, commit_fire})
                2'b10:   count_d = count_q + ONE;
                2'b01:   count_d = count_q - ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_q  <= FIRST_TAG;
            tail_q  <= FIRST_TAG;
            count_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Busy/ready bits: set on allocate, ready on writeback, cleared on commit or flush
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q  <= '0;
            ready_q <= '0;
        end else if (mispredict) begin
            busy_q  <= '0;
            ready_q <= '0;
        end else begin
            if (alloc_fire) begin
                busy_q[tail_q]  <= 1'b1;
                ready_q[tail_q] <= 1'b0;
            end
            if (ex_wb)  ready_q[target_ROB_pos]     <= 1'b1;
            if (slb_wb) ready_q[slb_target_ROB_pos] <= 1'b1;
            if (commit_fire) begin
                busy_q[head_q]  <= 1'b0;
                ready_q[head_q] <= 1'b0;
            end
        end
    end

    // Entry payload writes; the SLBuffer write comes last so it wins a tag clash
    // NOTE: the payload array has no reset; it is only read behind busy/ready, which are reset.
    always_ff @(posedge clk_in) begin
        if (alloc_fire) begin
            type_q[tail_q]     <= rob_type_e'(issue_type);
            rd_q[tail_q]       <= issue_rd;
            pred_npc_q[tail_q] <= issue_pred_npc;
        end
        if (ex_wb) begin
            value_q[target_ROB_pos]   <= V_ex;
            act_npc_q[target_ROB_pos] <= ex_npc;
        end
        if (slb_wb) begin
            value_q[slb_target_ROB_pos] <= V_slb;
        end
    end

    // Commit outputs, registered one cycle after the retire decision
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            commit_reg_valid_q   <= 1'b0;
            commit_rd_q          <= '0;
            commit_value_q       <= '0;
            commit_tag_q         <= '0;
            commit_store_valid_q <= 1'b0;
            control_hazard_q     <= 1'b0;
            redirect_pc_q        <= '0;
        end else if (!rdy_in) begin
            commit_reg_valid_q   <= 1'b0;
            commit_store_valid_q <= 1'b0;
            control_hazard_q     <= 1'b0;
        end else begin
            commit_reg_valid_q   <= commit_fire
                                    && ((head_type == ROB_REG) || (head_type == ROB_JUMP))
                                    && (rd_q[head_q] != '0);
            commit_store_valid_q <= commit_fire && (head_type == ROB_STORE);
            control_hazard_q     <= mispredict;
            if (commit_fire) begin
                commit_rd_q    <= rd_q[head_q];
                commit_value_q <= value_q[head_q];
                commit_tag_q   <= head_q;
            end
            if (mispredict) begin
                redirect_pc_q <= act_npc_q[head_q];
            end
        end
    end

    assign commit_reg_valid   = commit_reg_valid_q;
    assign commit_rd          = commit_rd_q;
    assign commit_value       = commit_value_q;
    assign commit_tag         = commit_tag_q;
    assign commit_store_valid = commit_store_valid_q;
    assign control_hazard     = control_hazard_q;
    assign redirect_pc        = redirect_pc_q;

    // Operand lookups see registered state only; tag 0 never reports ready
    assign query_ready1 = (query_tag1 != NO_TAG) && busy_q[query_tag1] && ready_q[query_tag1];
    assign query_ready2 = (query_tag2 != NO_TAG) && busy_q[query_tag2] && ready_q[query_tag2];
    assign query_value1 = query_ready1 ? value_q[query_tag1] : 32'd0;
    assign query_value2 = query_ready2 ? value_q[query_tag2] : 32'd0;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: in-order retirement, full/wrap,
// mispredict flush, store/jump commit, count and stall, operand query.
module tb_reorder_buffer;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        issue_valid;
    logic [1:0]  issue_type;
    logic [4:0]  issue_rd;
    logic [31:0] issue_pred_npc;
    logic [3:0]  alloc_tag;
    logic        rob_full;
    logic        update_control;
    logic [3:0]  target_ROB_pos;
    logic [31:0] V_ex;
    logic [31:0] ex_npc;
    logic        has_slb_result;
    logic [3:0]  slb_target_ROB_pos;
    logic [31:0] V_slb;
    logic [3:0]  query_tag1;
    logic [3:0]  query_tag2;
    logic        query_ready1;
    logic        query_ready2;
    logic [31:0] query_value1;
    logic [31:0] query_value2;
    logic        commit_reg_valid;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value;
    logic [3:0]  commit_tag;
    logic        commit_store_valid;
    logic        control_hazard;
    logic [31:0] redirect_pc;

    int n_checks;
    int n_errors;

    reorder_buffer #(.Q_WIDTH(4), .REG_ADDR_WIDTH(5)) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .rdy_in             (rdy_in),
        .issue_valid        (issue_valid),
        .issue_type         (issue_type),
        .issue_rd           (issue_rd),
        .issue_pred_npc     (issue_pred_npc),
        .alloc_tag          (alloc_tag),
        .rob_full           (rob_full),
        .update_control     (update_control),
        .target_ROB_pos     (target_ROB_pos),
        .V_ex               (V_ex),
        .ex_npc             (ex_npc),
        .has_slb_result     (has_slb_result),
        .slb_target_ROB_pos (slb_target_ROB_pos),
        .V_slb              (V_slb),
        .query_tag1         (query_tag1),
        .query_tag2         (query_tag2),
        .query_ready1       (query_ready1),
        .query_ready2       (query_ready2),
        .query_value1       (query_value1),
        .query_value2       (query_value2),
        .commit_reg_valid   (commit_reg_valid),
        .commit_rd          (commit_rd),
        .commit_value       (commit_value),
        .commit_tag         (commit_tag),
        .commit_store_valid (commit_store_valid),
        .control_hazard     (control_hazard),
        .redirect_pc        (redirect_pc)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // One clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic apply_reset();
        rst_in             = 1'b1;
        rdy_in             = 1'b1;
        issue_valid        = 1'b0;
        issue_type         = 2'd0;
        issue_rd           = 5'd0;
        issue_pred_npc     = 32'd0;
        update_control     = 1'b0;
        target_ROB_pos     = 4'd0;
        V_ex               = 32'd0;
        ex_npc             = 32'd0;
        has_slb_result     = 1'b0;
        slb_target_ROB_pos = 4'd0;
        V_slb              = 32'd0;
        query_tag1         = 4'd0;
        query_tag2         = 4'd0;
        tick();
        tick();
        rst_in = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        #1;
        n_checks++;
        if ({alloc_tag, rob_full} !== {4'd1, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_ptr: got tag=%0d full=%0b, want tag=1 full=0", alloc_tag, rob_full);
        end
        n_checks++;
        if ({commit_reg_valid, commit_store_valid, control_hazard, commit_rd, commit_value,
             commit_tag, redirect_pc, query_ready1, query_value1} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got rv=%0b sv=%0b ch=%0b rd=%0d val=%h tag=%0d pc=%h qr=%0b qv=%h, want all 0",
                     commit_reg_valid, commit_store_valid, control_hazard, commit_rd, commit_value,
                     commit_tag, redirect_pc, query_ready1, query_value1);
        end
        apply_reset();
    endtask

    task automatic test_in_order();
        apply_reset();
        issue_valid = 1'b1;
        issue_type  = 2'd0;
        for (int i = 1; i <= 3; i++) begin
            issue_rd = 5'(i);
            n_checks++;
            if (alloc_tag !== 4'(i)) begin
                n_errors++;
                $display("FAIL alloc_tag_%0d: got %0d, want %0d", i, alloc_tag, i);
            end
            tick();
        end
        issue_valid    = 1'b0;
        update_control = 1'b1;
        target_ROB_pos = 4'd3; V_ex = 32'd30;
        tick();
        target_ROB_pos = 4'd1; V_ex = 32'd10;
        tick();
        n_checks++;
        if (commit_reg_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL early_commit: got rv=%0b, want 0", commit_reg_valid);
        end
        target_ROB_pos = 4'd2; V_ex = 32'd20;
        tick();
        n_checks++;
        if ({commit_reg_valid, commit_rd, commit_value, commit_tag} !== {1'b1, 5'd1, 32'd10, 4'd1}) begin
            n_errors++;
            $display("FAIL commit1: got rv=%0b rd=%0d val=%0d tag=%0d, want 1 1 10 1",
                     commit_reg_valid, commit_rd, commit_value, commit_tag);
        end
        update_control = 1'b0;
        tick();
        n_checks++;
        if ({commit_reg_valid, commit_rd, commit_value, commit_tag} !== {1'b1, 5'd2, 32'd20, 4'd2}) begin
            n_errors++;
            $display("FAIL commit2: got rv=%0b rd=%0d val=%0d tag=%0d, want 1 2 20 2",
                     commit_reg_valid, commit_rd, commit_value, commit_tag);
        end
        tick();
        n_checks++;
        if ({commit_reg_valid, commit_rd, commit_value, commit_tag} !== {1'b1, 5'd3, 32'd30, 4'd3}) begin
            n_errors++;
            $display("FAIL commit3: got rv=%0b rd=%0d val=%0d tag=%0d, want 1 3 30 3",
                     commit_reg_valid, commit_rd, commit_value, commit_tag);
        end
        tick();
        n_checks++;
        if ({commit_reg_valid, alloc_tag} !== {1'b0, 4'd4}) begin
            n_errors++;
            $display("FAIL drain: got rv=%0b tag=%0d, want rv=0 tag=4", commit_reg_valid, alloc_tag);
        end
    endtask

    task automatic test_full_wrap();
        apply_reset();
        issue_valid = 1'b1;
        issue_type  = 2'd0;
        issue_rd    = 5'd5;
        for (int i = 0; i < 15; i++) tick();
        n_checks++;
        if ({rob_full, alloc_tag} !== {1'b1, 4'd1}) begin
            n_errors++;
            $display("FAIL full: got full=%0b tag=%0d, want full=1 tag=1", rob_full, alloc_tag);
        end
        tick();  // 16th issue while full
        n_checks++;
        if ({rob_full, alloc_tag} !== {1'b1, 4'd1}) begin
            n_errors++;
            $display("FAIL issue_when_full: got full=%0b tag=%0d, want full=1 tag=1", rob_full, alloc_tag);
        end
        issue_valid    = 1'b0;
        update_control = 1'b1;
        target_ROB_pos = 4'd1; V_ex = 32'd7;
        tick();
        update_control = 1'b0;
        issue_valid    = 1'b1;  // still full before this edge: refused
        tick();
        n_checks++;
        if ({commit_reg_valid, commit_tag, rob_full, alloc_tag} !== {1'b1, 4'd1, 1'b0, 4'd1}) begin
            n_errors++;
            $display("FAIL full_commit: got rv=%0b ctag=%0d full=%0b atag=%0d, want 1 1 0 1",
                     commit_reg_valid, commit_tag, rob_full, alloc_tag);
        end
        tick();
        n_checks++;
        if ({rob_full, alloc_tag} !== {1'b1, 4'd2}) begin
            n_errors++;
            $display("FAIL wrap_alloc: got full=%0b tag=%0d, want full=1 tag=2", rob_full, alloc_tag);
        end
        issue_valid = 1'b0;
    endtask

    task automatic test_mispredict();
        apply_reset();
        issue_valid = 1'b1;
        issue_type = 2'd0; issue_rd = 5'd4; issue_pred_npc = 32'h100;
        tick();
        issue_type = 2'd1; issue_rd = 5'd0; issue_pred_npc = 32'h104;
        tick();
        issue_type = 2'd0; issue_rd = 5'd5; issue_pred_npc = 32'h108;
        tick();
        issue_valid    = 1'b0;
        update_control = 1'b1;
        target_ROB_pos = 4'd2; V_ex = 32'd0; ex_npc = 32'h200;
        tick();
        target_ROB_pos = 4'd1; V_ex = 32'd11; ex_npc = 32'h104;
        tick();
        update_control = 1'b0;
        tick();
        n_checks++;
        if ({commit_reg_valid, commit_rd, commit_value, control_hazard} !== {1'b1, 5'd4, 32'd11, 1'b0}) begin
            n_errors++;
            $display("FAIL pre_branch_commit: got rv=%0b rd=%0d val=%0d ch=%0b, want 1 4 11 0",
                     commit_reg_valid, commit_rd, commit_value, control_hazard);
        end
        tick();
        n_checks++;
        if ({control_hazard, redirect_pc, commit_reg_valid, alloc_tag, rob_full}
            !== {1'b1, 32'h200, 1'b0, 4'd1, 1'b0}) begin
            n_errors++;
            $display("FAIL mispredict: got ch=%0b pc=%h rv=%0b tag=%0d full=%0b, want 1 00000200 0 1 0",
                     control_hazard, redirect_pc, commit_reg_valid, alloc_tag, rob_full);
        end
        issue_valid = 1'b1;  // wrong-path issue during the flush pulse
        issue_type  = 2'd0;
        tick();
        n_checks++;
        if ({control_hazard, alloc_tag} !== {1'b0, 4'd1}) begin
            n_errors++;
            $display("FAIL flush_pulse: got ch=%0b tag=%0d, want ch=0 tag=1", control_hazard, alloc_tag);
        end
        tick();
        n_checks++;
        if (alloc_tag !== 4'd2) begin
            n_errors++;
            $display("FAIL post_flush_alloc: got tag=%0d, want 2", alloc_tag);
        end
        issue_valid = 1'b0;
    endtask

    task automatic test_store_jump();
        apply_reset();
        issue_valid = 1'b1;
        issue_type = 2'd0; issue_rd = 5'd0;
        for (int i = 0; i < 3; i++) tick();  // tags 1..3 write x0
        issue_type = 2'd2; issue_rd = 5'd0;
        tick();                              // tag 4 store
        issue_type = 2'd3; issue_rd = 5'd9; issue_pred_npc = 32'h300;
        tick();                              // tag 5 jump-link
        issue_valid    = 1'b0;
        update_control = 1'b1; target_ROB_pos = 4'd1; V_ex = 32'd1; ex_npc = 32'd0;
        has_slb_result = 1'b1; slb_target_ROB_pos = 4'd4; V_slb = 32'h1000;
        tick();
        has_slb_result = 1'b0;
        target_ROB_pos = 4'd2; V_ex = 32'd2;
        tick();
        n_checks++;
        if ({commit_reg_valid, commit_store_valid, commit_tag} !== {1'b0, 1'b0, 4'd1}) begin
            n_errors++;
            $display("FAIL rd0_commit: got rv=%0b sv=%0b tag=%0d, want 0 0 1",
                     commit_reg_valid, commit_store_valid, commit_tag);
        end
        target_ROB_pos = 4'd3; V_ex = 32'd3;
        tick();
        target_ROB_pos = 4'd5; V_ex = 32'h55; ex_npc = 32'h300;
        tick();
        update_control = 1'b0;
        tick();
        n_checks++;
        if ({commit_store_valid, commit_tag, commit_reg_valid} !== {1'b1, 4'd4, 1'b0}) begin
            n_errors++;
            $display("FAIL store_commit: got sv=%0b tag=%0d rv=%0b, want 1 4 0",
                     commit_store_valid, commit_tag, commit_reg_valid);
        end
        tick();
        n_checks++;
        if ({commit_reg_valid, commit_rd, commit_value, commit_store_valid, control_hazard}
            !== {1'b1, 5'd9, 32'h55, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL jump_commit: got rv=%0b rd=%0d val=%h sv=%0b ch=%0b, want 1 9 00000055 0 0",
                     commit_reg_valid, commit_rd, commit_value, commit_store_valid, control_hazard);
        end
    endtask

    task automatic test_count_stall();
        apply_reset();
        issue_valid = 1'b1;
        issue_type  = 2'd0;
        issue_rd    = 5'd6;
        for (int i = 0; i < 7; i++) tick();  // tags 1..7, count 7
        issue_valid    = 1'b0;
        update_control = 1'b1; target_ROB_pos = 4'd1; V_ex = 32'd1;
        tick();
        update_control = 1'b0;
        issue_valid    = 1'b1;
        tick();                              // allocate tag 8 and commit tag 1
        n_checks++;
        if ({commit_reg_valid, commit_value, alloc_tag} !== {1'b1, 32'd1, 4'd9}) begin
            n_errors++;
            $display("FAIL alloc_and_commit: got rv=%0b val=%0d tag=%0d, want 1 1 9",
                     commit_reg_valid, commit_value, alloc_tag);
        end
        for (int i = 0; i < 7; i++) tick();  // count 14
        n_checks++;
        if (rob_full !== 1'b0) begin
            n_errors++;
            $display("FAIL count14: got full=%0b, want 0", rob_full);
        end
        tick();                              // count 15
        n_checks++;
        if ({rob_full, alloc_tag} !== {1'b1, 4'd2}) begin
            n_errors++;
            $display("FAIL count15: got full=%0b tag=%0d, want full=1 tag=2", rob_full, alloc_tag);
        end
        issue_valid    = 1'b0;
        update_control = 1'b1; target_ROB_pos = 4'd2; V_ex = 32'd2;
        tick();
        rdy_in = 1'b0;
        target_ROB_pos = 4'd3; V_ex = 32'd3;  // ignored while stalled
        query_tag1 = 4'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({commit_reg_valid, rob_full, alloc_tag} !== {1'b0, 1'b1, 4'd2}) begin
                n_errors++;
                $display("FAIL stall_%0d: got rv=%0b full=%0b tag=%0d, want 0 1 2",
                         i, commit_reg_valid, rob_full, alloc_tag);
            end
        end
        update_control = 1'b0;
        n_checks++;
        if (query_ready1 !== 1'b0) begin
            n_errors++;
            $display("FAIL stall_wb_ignored: got ready=%0b, want 0", query_ready1);
        end
        rdy_in = 1'b1;
        tick();
        n_checks++;
        if ({commit_reg_valid, commit_value, commit_tag, rob_full} !== {1'b1, 32'd2, 4'd2, 1'b0}) begin
            n_errors++;
            $display("FAIL resume_commit: got rv=%0b val=%0d tag=%0d full=%0b, want 1 2 2 0",
                     commit_reg_valid, commit_value, commit_tag, rob_full);
        end
        query_tag1 = 4'd0;
    endtask

    task automatic test_query();
        apply_reset();
        issue_valid = 1'b1;
        issue_type  = 2'd0;
        issue_rd    = 5'd7;
        for (int i = 0; i < 5; i++) tick();
        issue_valid    = 1'b0;
        query_tag1     = 4'd5;
        query_tag2     = 4'd4;
        update_control = 1'b1; target_ROB_pos = 4'd5; V_ex = 32'hDEAD;
        #1;
        n_checks++;
        if ({query_ready1, query_value1} !== {1'b0, 32'd0}) begin
            n_errors++;
            $display("FAIL query_no_bypass: got ready=%0b val=%h, want 0 00000000", query_ready1, query_value1);
        end
        tick();
        update_control = 1'b0;
        #1;
        n_checks++;
        if ({query_ready1, query_value1, query_ready2} !== {1'b1, 32'hDEAD, 1'b0}) begin
            n_errors++;
            $display("FAIL query_hit: got r1=%0b v1=%h r2=%0b, want 1 0000dead 0",
                     query_ready1, query_value1, query_ready2);
        end
        query_tag2 = 4'd0;
        #1;
        n_checks++;
        if ({query_ready2, query_value2} !== {1'b0, 32'd0}) begin
            n_errors++;
            $display("FAIL query_tag0: got ready=%0b val=%h, want 0 00000000", query_ready2, query_value2);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        apply_reset();
        test_reset();
        test_in_order();
        test_full_wrap();
        test_mispredict();
        test_store_jump();
        test_count_stall();
        test_query();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
